alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Parametrised Wishbone-slave ALU front end. Owns NCH DSP lanes and arbitrates them between direct DSP operations and one shared function engine (SIN/COS/1/(1+x) class).
- Adds over the previous generation: explicit request latching, stall while busy, configurable DSP latency, per-request error reporting, function-engine timeout/abort, and cycle-drop abort.
- Sits between the Wishbone interconnect and the external dsp48a1 lane instances plus the function engine.

Parameters:
- NCH, 2, number of DSP lanes (channels); all per-lane buses are flattened, lane 0 in the LSBs.
- A_W, 18, width of the A and B operands and of the function results.
- C_W, 48, width of the C operand and of the P result.
- DSP_LAT, 3, cycles from dsp_* inputs being presented to dsp_p being valid (≥1).
- NUM_FN, 3, number of function codes supported; function-mode op < NUM_FN is legal.
- TIMEOUT, 255, maximum cycles to wait for fn_done (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_cycle  in  1  Wishbone CYC
- alu_strobe  in  1  Wishbone STB
- alu_ack  out  1  one-cycle completion pulse
- alu_err  out  1  one-cycle error pulse (replaces ack)
- alu_stall  out  1  busy; request not accepted
- alu_mode  in  1  1 = DSP mode, 0 = function mode
- alu_op  in  8  DSP opcode or function code
- alu_a  in  NCH*A_W  A operands
- alu_b  in  NCH*A_W  B operands
- alu_c  in  NCH*C_W  C operands
- alu_p  out  NCH*C_W  results
- dsp_op  out  8  to all lanes
- dsp_a  out  NCH*A_W  lane A inputs
- dsp_b  out  NCH*A_W  lane B inputs
- dsp_c  out  NCH*C_W  lane C inputs
- dsp_p  in  NCH*C_W  lane P outputs
- fn_start  out  1  one-cycle start pulse
- fn_abort  out  1  one-cycle abort pulse
- fn_sel  out  8  latched function code
- fn_x  out  NCH*A_W  latched arguments (from alu_a)
- fn_done  in  1  engine completion pulse
- fn_res  in  NCH*A_W  engine results, signed
- fn_dsp_op  in  8  engine DSP request
- fn_dsp_a  in  NCH*A_W  engine DSP request
- fn_dsp_b  in  NCH*A_W  engine DSP request
- fn_dsp_c  in  NCH*C_W  engine DSP request
- fn_dsp_p  out  NCH*C_W  dsp_p forwarded to the engine (always driven)

Behaviour:
- Reset state:
  - FSM in IDLE.
  - alu_ack = alu_err = fn_start = fn_abort = 0; alu_stall = 0.
  - alu_p = 0; dsp_op/a/b/c = 0; fn_sel = fn_x = 0; counters = 0.
- States: IDLE, DSP_RUN, FN_START, FN_RUN, RESP.
- Accept: in IDLE, when alu_cycle && alu_strobe, latch mode, op, a, b and c. The clock edge on which this happens is T. alu_stall is 1 in every state except IDLE.
- DSP mode:
  - Go to DSP_RUN; dsp_* are driven from the latched values from T+1 and held for DSP_LAT+1 cycles.
  - A latency counter starts at T+1; dsp_p is sampled in cycle T+1+DSP_LAT and registered into alu_p.
  - Go to RESP; alu_ack = 1 in cycle T+2+DSP_LAT (T+5 for the default DSP_LAT).
- Function mode, op ≥ NUM_FN: go straight to RESP, alu_err = 1 in cycle T+1, alu_p = 0, and the engine is never started.
- Function mode, op < NUM_FN:
  - FN_START: fn_start = 1 for exactly one cycle (T+1); fn_sel and fn_x hold their latched values until the request ends.
  - FN_RUN: dsp_* mux to fn_dsp_*, and the timeout counter counts.
  - On fn_done: alu_p lane i = fn_res lane i sign-extended to C_W; RESP; alu_ack the next cycle.
  - If the counter reaches TIMEOUT with no fn_done: fn_abort = 1 and alu_err = 1 in the same cycle, then IDLE.
  - fn_done arriving in the same cycle as the timeout is treated as a success.
- RESP: one cycle with alu_ack (or alu_err) = 1, then IDLE. alu_p holds until the next completion.
- Outside DSP_RUN and FN_RUN, dsp_op and the operands are 0 (NOP).
- alu_cycle deasserted in any non-IDLE state:
  - Go to IDLE next cycle, with no ack and no err.
  - If the engine is running, pulse fn_abort.
  - alu_p is not updated.
- A strobe during stall is ignored; the master must hold it.
- Back-to-back: a strobe in the cycle after RESP (IDLE) is accepted.
- ack and err are never both 1.
- Reset mid-operation returns everything to reset values on the next edge; fn_abort is not pulsed.

Test Plan:
- DSP mode, NCH=2, DSP_LAT=3, op=multiply, a=3/5, b=4/-2, model P=A*B -> alu_p lanes 12/-10 with alu_ack in cycle T+5; stall high T+1..T+5.
- Function op=0, engine model returns fn_res 0x1FFFF/0x20000 after 10 cycles -> fn_start at T+1, alu_p = 0x1FFFF / sign-extended 0xFFFFFFFE0000, ack one cycle after fn_done.
- Function op=7 with NUM_FN=3 -> alu_err in cycle T+1, no fn_start, no ack.
- Engine never asserts fn_done, TIMEOUT=16 -> fn_abort and alu_err together, 16 cycles into FN_RUN; the next request is accepted.
- alu_cycle dropped two cycles into DSP_RUN -> no ack or err, dsp_op = 0 the cycle after, alu_p unchanged.
- Reset asserted mid-FN_RUN -> all outputs 0 on the next edge; a strobe after release is accepted normally.

Source files
------------

// File: rtl/alu_dispatch.sv
// alu_dispatch: Wishbone-slave ALU front end that arbitrates NCH DSP lanes
// between direct DSP operations and a shared function engine.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_cycle/strobe/ack/err/stall  Wishbone handshake
//   alu_mode, alu_op                1 = DSP op, 0 = function code
//   alu_a/b/c, alu_p                per-lane operands and results (lane 0 in LSBs)
//   dsp_op/a/b/c, dsp_p             shared lane inputs and lane results
//   fn_start/abort/sel/x            function engine control and arguments
//   fn_done/res                     function engine completion and results
//   fn_dsp_op/a/b/c, fn_dsp_p       engine access to the DSP lanes
module alu_dispatch #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned A_W     = 18,
  parameter int unsigned C_W     = 48,
  parameter int unsigned DSP_LAT = 3,
  parameter int unsigned NUM_FN  = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_cycle,
  input  logic                 alu_strobe,
  output logic                 alu_ack,
  output logic                 alu_err,
  output logic                 alu_stall,
  input  logic                 alu_mode,
  input  logic [7:0]           alu_op,
  input  logic [NCH*A_W-1:0]   alu_a,
  input  logic [NCH*A_W-1:0]   alu_b,
  input  logic [NCH*C_W-1:0]   alu_c,
  output logic [NCH*C_W-1:0]   alu_p,
  output logic [7:0]           dsp_op,
  output logic [NCH*A_W-1:0]   dsp_a,
  output logic [NCH*A_W-1:0]   dsp_b,
  output logic [NCH*C_W-1:0]   dsp_c,
  input  logic [NCH*C_W-1:0]   dsp_p,
  output logic                 fn_start,
  output logic                 fn_abort,
  output logic [7:0]           fn_sel,
  output logic [NCH*A_W-1:0]   fn_x,
  input  logic                 fn_done,
  input  logic [NCH*A_W-1:0]   fn_res,
  input  logic [7:0]           fn_dsp_op,
  input  logic [NCH*A_W-1:0]   fn_dsp_a,
  input  logic [NCH*A_W-1:0]   fn_dsp_b,
  input  logic [NCH*C_W-1:0]   fn_dsp_c,
  output logic [NCH*C_W-1:0]   fn_dsp_p
);

  localparam int unsigned AW_T    = NCH * A_W;
  localparam int unsigned CW_T    = NCH * C_W;
  localparam int unsigned CNT_MAX = (DSP_LAT > TIMEOUT) ? DSP_LAT : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DSP_RUN  = 3'd1,
    FN_START = 3'd2,
    FN_RUN   = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        op_q;
  logic [AW_T-1:0]   a_q;
  logic [AW_T-1:0]   b_q;
  logic [CW_T-1:0]   c_q;
  logic [CW_T-1:0]   fn_res_sx;

  // Engine results are signed; widen each lane to C_W.
  always_comb begin
    fn_res_sx = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      fn_res_sx[i*C_W +: C_W] = {{(C_W-A_W){fn_res[i*A_W + A_W - 1]}}, fn_res[i*A_W +: A_W]};
    end
  end

  // Lane input mux: latched request in DSP_RUN, engine in FN_RUN, NOP otherwise.
  always_comb begin
    dsp_op = '0;
    dsp_a  = '0;
    dsp_b  = '0;
    dsp_c  = '0;
    case (state)
      DSP_RUN: begin
        dsp_op = op_q;
        dsp_a  = a_q;
        dsp_b  = b_q;
        dsp_c  = c_q;
      end
      FN_RUN: begin
        dsp_op = fn_dsp_op;
        dsp_a  = fn_dsp_a;
        dsp_b  = fn_dsp_b;
        dsp_c  = fn_dsp_c;
      end
      default: ;
    endcase
  end

  assign fn_dsp_p  = dsp_p;
  assign alu_stall = (state != IDLE);

  // Request FSM with registered response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      alu_ack  <= 1'b0;
      alu_err  <= 1'b0;
      alu_p    <= '0;
      fn_start <= 1'b0;
      fn_abort <= 1'b0;
      fn_sel   <= '0;
      fn_x     <= '0;
    end else begin
      alu_ack  <= 1'b0;
      alu_err  <= 1'b0;
      fn_start <= 1'b0;
      fn_abort <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          fn_sel <= '0;
          fn_x   <= '0;
          if (alu_cycle && alu_strobe) begin
            op_q <= alu_op;
            a_q  <= alu_a;
            b_q  <= alu_b;
            c_q  <= alu_c;
            if (alu_mode) begin
              state <= DSP_RUN;
            end else if (32'(alu_op) < 32'(NUM_FN)) begin
              state    <= FN_START;
              fn_start <= 1'b1;
              fn_sel   <= alu_op;
              fn_x     <= alu_a;
            end else begin
              // Unsupported function code: fail without touching the engine.
              state   <= RESP;
              alu_err <= 1'b1;
              alu_p   <= '0;
            end
          end
        end
        DSP_RUN: begin
          if (!alu_cycle) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(DSP_LAT)) begin
            alu_p   <= dsp_p;
            alu_ack <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FN_START: begin
          if (!alu_cycle) begin
            state    <= IDLE;
            fn_abort <= 1'b1;
          end else begin
            state <= FN_RUN;
          end
        end
        FN_RUN: begin
          // fn_done wins over a simultaneous timeout.
          if (!alu_cycle) begin
            state    <= IDLE;
            fn_abort <= 1'b1;
          end else if (fn_done) begin
            alu_p   <= fn_res_sx;
            alu_ack <= 1'b1;
            state   <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            fn_abort <= 1'b1;
            alu_err  <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

  localparam int unsigned NCH     = 2;
  localparam int unsigned A_W     = 18;
  localparam int unsigned C_W     = 48;
  localparam int unsigned DSP_LAT = 3;
  localparam int unsigned NUM_FN  = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned AW      = NCH * A_W;
  localparam int unsigned CW      = NCH * C_W;

  logic           clk = 1'b0;
  logic           reset;
  logic           alu_cycle, alu_strobe, alu_ack, alu_err, alu_stall, alu_mode;
  logic [7:0]     alu_op;
  logic [AW-1:0]  alu_a, alu_b;
  logic [CW-1:0]  alu_c, alu_p;
  logic [7:0]     dsp_op;
  logic [AW-1:0]  dsp_a, dsp_b;
  logic [CW-1:0]  dsp_c, dsp_p;
  logic           fn_start, fn_abort, fn_done;
  logic [7:0]     fn_sel, fn_dsp_op;
  logic [AW-1:0]  fn_x, fn_res, fn_dsp_a, fn_dsp_b;
  logic [CW-1:0]  fn_dsp_c, fn_dsp_p;

  alu_dispatch #(
    .NCH(NCH), .A_W(A_W), .C_W(C_W), .DSP_LAT(DSP_LAT), .NUM_FN(NUM_FN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_cycle(alu_cycle), .alu_strobe(alu_strobe), .alu_ack(alu_ack), .alu_err(alu_err),
    .alu_stall(alu_stall), .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_p(alu_p),
    .dsp_op(dsp_op), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .fn_start(fn_start), .fn_abort(fn_abort), .fn_sel(fn_sel), .fn_x(fn_x),
    .fn_done(fn_done), .fn_res(fn_res),
    .fn_dsp_op(fn_dsp_op), .fn_dsp_a(fn_dsp_a), .fn_dsp_b(fn_dsp_b), .fn_dsp_c(fn_dsp_c),
    .fn_dsp_p(fn_dsp_p)
  );

  always #5 clk = ~clk;

  // DSP lane model: op 1 = A*B, op 2 = A*B+C, else 0; DSP_LAT register stages.
  function automatic logic [CW-1:0] dsp_f(input logic [7:0] op, input logic [AW-1:0] a,
                                          input logic [AW-1:0] b, input logic [CW-1:0] c);
    logic [CW-1:0] r;
    logic signed [C_W-1:0] ax, bx;
    r = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      ax = {{(C_W-A_W){a[i*A_W + A_W - 1]}}, a[i*A_W +: A_W]};
      bx = {{(C_W-A_W){b[i*A_W + A_W - 1]}}, b[i*A_W +: A_W]};
      if (op == 8'd1)      r[i*C_W +: C_W] = ax * bx;
      else if (op == 8'd2) r[i*C_W +: C_W] = ax * bx + c[i*C_W +: C_W];
    end
    return r;
  endfunction

  logic [CW-1:0] pipe [DSP_LAT];
  always @(posedge clk) begin
    pipe[0] <= dsp_f(dsp_op, dsp_a, dsp_b, dsp_c);
    for (int i = 1; i < int'(DSP_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign dsp_p = pipe[DSP_LAT-1];

  localparam logic [CW-1:0] P_MUL = {48'hFFFF_FFFF_FFF6, 48'd12};
  localparam logic [CW-1:0] P_FN  = {48'hFFFF_FFFE_0000, 48'h0000_0001_FFFF};
  localparam logic [CW-1:0] P_MAC = {48'h0003_FFFC_0001, 48'h0000_0000_012C};
  localparam logic [AW-1:0] A_MUL = {18'd5, 18'd3};
  localparam logic [AW-1:0] B_MUL = {18'h3FFFE, 18'd4};
  localparam logic [AW-1:0] A_MAC = {18'h1FFFF, 18'h3FFF9};
  localparam logic [AW-1:0] B_MAC = {18'h1FFFF, 18'd100};
  localparam logic [CW-1:0] C_MAC = {48'd0, 48'd1000};
  localparam logic [AW-1:0] A_FN  = {18'h00ABC, 18'h12345};

  typedef struct {
    logic          ack;
    logic          err;
    logic [CW-1:0] p;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one accepted edge; k counts cycles after acceptance.
  task automatic req(input logic push, input logic mode, input logic [7:0] op,
                     input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [CW-1:0] c,
                     input logic eack, input logic eerr, input logic [CW-1:0] ep, input int elat);
    exp_t e;
    if (push) begin
      e.ack = eack; e.err = eerr; e.p = ep; e.lat = elat;
      sb.push_back(e);
    end
    alu_cycle = 1'b1; alu_strobe = 1'b1; alu_mode = mode; alu_op = op;
    alu_a = a; alu_b = b; alu_c = c;
    cyc();
    alu_strobe = 1'b0;
    k = 1;
  endtask

  // Wait (bounded) for ack/err, then compare against the scoreboard head.
  task automatic wait_resp(input string tag);
    exp_t e;
    while (!(alu_ack || alu_err) && k < 300) begin
      cyc();
      k++;
    end
    chk({tag, "_sb"}, 128'(sb.size()), 128'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_lat"}, 128'(k), 128'(e.lat));
    chk({tag, "_ack"}, 128'(alu_ack), 128'(e.ack));
    chk({tag, "_err"}, 128'(alu_err), 128'(e.err));
    chk({tag, "_p"},   128'(alu_p), 128'(e.p));
  endtask

  initial begin
    reset = 1'b1; alu_cycle = 1'b0; alu_strobe = 1'b0; alu_mode = 1'b0; alu_op = '0;
    alu_a = '0; alu_b = '0; alu_c = '0; fn_done = 1'b0; fn_res = {18'h20000, 18'h1FFFF};
    fn_dsp_op = 8'hA5; fn_dsp_a = {18'h0F0F0, 18'h11111}; fn_dsp_b = {18'h2AAAA, 18'h15555};
    fn_dsp_c = {48'h1234_5678_9ABC, 48'h0FED_CBA9_8765};
    repeat (4) cyc();

    // Reset state
    chk("rst_state", {alu_ack, alu_err, alu_stall, fn_start, fn_abort}, 5'b0);
    chk("rst_p", alu_p, 0);
    chk("rst_dsp", {dsp_op, dsp_a, dsp_b, dsp_c}, 0);
    chk("rst_fn", {fn_sel, fn_x}, 0);
    reset = 1'b0;
    cyc();

    // DSP multiply
    req(1, 1, 8'd1, A_MUL, B_MUL, '0, 1, 0, P_MUL, 5);
    chk("mul_stall1", alu_stall, 1);
    chk("mul_dsp_a", dsp_a, A_MUL);
    wait_resp("mul");
    chk("mul_stall5", alu_stall, 1);
    cyc();
    chk("mul_ack_pulse", {alu_ack, alu_err, alu_stall}, 3'b0);

    // Function op 0, engine answers after 10 cycles
    req(1, 0, 8'd0, A_FN, '0, '0, 1, 0, P_FN, 12);
    chk("fn_start1", fn_start, 1);
    chk("fn_sel", fn_sel, 0);
    chk("fn_x", fn_x, A_FN);
    cyc(); k++;
    chk("fn_start2", fn_start, 0);
    cyc(); k++;
    chk("fn_mux_op", dsp_op, 8'hA5);
    chk("fn_mux_b", dsp_b, fn_dsp_b);
    chk("fn_dsp_p", fn_dsp_p, dsp_p);
    chk("fn_x_hold", fn_x, A_FN);
    while (k < 11) begin cyc(); k++; end
    fn_done = 1'b1;
    cyc(); k++;
    fn_done = 1'b0;
    wait_resp("fn0");

    // Timeout: engine silent, abort with err 16 cycles into FN_RUN
    cyc();
    req(1, 0, 8'd1, A_MUL, '0, '0, 0, 1, P_FN, 2 + int'(TIMEOUT));
    wait_resp("tmo");
    chk("tmo_abort", fn_abort, 1);
    chk("tmo_stall", alu_stall, 0);

    // Next request accepted straight away
    req(1, 1, 8'd2, A_MAC, B_MAC, C_MAC, 1, 0, P_MAC, 5);
    wait_resp("mac");
    cyc();

    // Cycle dropped two cycles into DSP_RUN
    req(0, 1, 8'd1, A_MUL, B_MUL, '0, 0, 0, '0, 0);
    cyc(); k++;
    chk("drop_op_live", dsp_op, 8'd1);
    alu_cycle = 1'b0;
    cyc(); k++;
    chk("drop_op_nop", dsp_op, 0);
    chk("drop_stall", alu_stall, 0);
    for (int i = 0; i < 6; i++) begin
      chk("drop_resp", {alu_ack, alu_err, fn_abort}, 3'b0);
      cyc();
    end
    chk("drop_p", alu_p, P_MAC);

    // Illegal function code
    req(1, 0, 8'd7, A_FN, '0, '0, 0, 1, '0, 1);
    chk("bad_nostart", fn_start, 0);
    wait_resp("badfn");
    cyc();
    chk("bad_after", {alu_ack, alu_err, fn_start, alu_stall}, 4'b0);

    // Reset mid FN_RUN
    req(1, 0, 8'd2, A_FN, '0, '0, 1, 0, '0, 0);
    while (k < 5) begin cyc(); k++; end
    chk("rst_mid_stall", alu_stall, 1);
    reset = 1'b1;
    cyc();
    sb.delete();
    chk("rst_mid_ctl", {alu_ack, alu_err, alu_stall, fn_start, fn_abort}, 5'b0);
    chk("rst_mid_p", alu_p, 0);
    chk("rst_mid_fn", {fn_sel, fn_x}, 0);
    chk("rst_mid_dsp", {dsp_op, dsp_a}, 0);
    reset = 1'b0;
    cyc();
    req(1, 1, 8'd1, A_MUL, B_MUL, '0, 1, 0, P_MUL, 5);
    wait_resp("post_rst");

    cyc();
    chk("sb_empty", 128'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
